// File: rtl/uart_pkg.sv
// Shared definitions for the inter-board UART link.
// Holds the frame opcodes, the sync-frame payload codes, the transmit FSM
// state type and the snapshot record. Both the TX encoder and the peer RX
// decoder import this package so the two ends agree on the frame format.
package uart_pkg;

  // Opcode in bits [2:0] of every frame; equals the frame's position in a burst.
  localparam logic [2:0] OP_SYNC    = 3'b000;
  localparam logic [2:0] OP_KEEP_LO = 3'b001;
  localparam logic [2:0] OP_KEEP_HI = 3'b010;
  localparam logic [2:0] OP_X_LO    = 3'b011;
  localparam logic [2:0] OP_X_HI    = 3'b100;
  localparam logic [2:0] OP_Y_LO    = 3'b101;
  localparam logic [2:0] OP_Y_HI    = 3'b110;
  localparam logic [2:0] OP_SCORE   = 3'b111;

  // Sync-frame payloads.
  localparam logic [4:0] SYNC_SHOOTER_START = 5'b11001;
  localparam logic [4:0] SYNC_START         = 5'b01001;
  localparam logic [4:0] SYNC_IDLE          = 5'b00001;

  localparam int unsigned FRAMES_PER_BURST = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Local game state captured once per burst.
  typedef struct packed {
    logic       local_shooter;
    logic       game_starts;
    logic [9:0] keeper_pos;
    logic [9:0] x_shooter;
    logic [9:0] y_shooter;
    logic [2:0] player_score;
    logic       is_scored;
    logic       multi_input;
  } snapshot_t;

endpackage

// File: rtl/uart_frame_builder.sv
// Combinational frame mux: selects one 8-bit frame of a snapshot.
// Ports:
//   snap  - captured game state
//   idx   - frame number 0..7
//   frame - {payload[4:0], opcode[2:0]} for that frame
module uart_frame_builder
  import uart_pkg::*;
(
  input  snapshot_t  snap,
  input  logic [2:0] idx,
  output logic [7:0] frame
);

  logic [4:0] sync_payload;

  always_comb begin
    if (snap.game_starts && snap.local_shooter) begin
      sync_payload = SYNC_SHOOTER_START;
    end else if (snap.game_starts) begin
      sync_payload = SYNC_START;
    end else begin
      // A shooter flag before game start still reports plain idle sync.
      sync_payload = SYNC_IDLE;
    end
  end

  always_comb begin
    // NOTE: assign a default before the case so no path leaves frame unassigned, which would infer a latch.
    frame = 8'h00;
    unique case (idx)
      3'd0: frame = {sync_payload,                       OP_SYNC};
      3'd1: frame = {snap.keeper_pos[4:0],               OP_KEEP_LO};
      3'd2: frame = {snap.keeper_pos[9:5],               OP_KEEP_HI};
      3'd3: frame = {snap.x_shooter[4:0],                OP_X_LO};
      3'd4: frame = {snap.x_shooter[9:5],                OP_X_HI};
      3'd5: frame = {snap.y_shooter[4:0],                OP_Y_LO};
      3'd6: frame = {snap.y_shooter[9:5],                OP_Y_HI};
      3'd7: frame = {snap.multi_input, snap.is_scored,
                     snap.player_score,                  OP_SCORE};
      default: frame = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_encoder.sv
// Transmit framing stage: on send_tick, snapshots the local game state and
// writes it to the UART TX FIFO as eight frames, each followed by
// GAP_CYCLES idle cycles (must be >= 1 so tx_full is re-sampled between writes).
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   send_tick      - one-cycle burst request, honoured only while idle
//   tx_full        - FIFO full; a write is held while it is high
//   local_shooter .. multi_input - game state to snapshot
//   wr_uart        - registered FIFO write strobe, one cycle per frame
//   w_data         - frame byte, valid while wr_uart is high
//   busy           - burst in progress
module uart_encoder
  import uart_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_tick,
  input  logic       tx_full,
  input  logic       local_shooter,
  input  logic       game_starts,
  input  logic [9:0] keeper_pos,
  input  logic [9:0] x_shooter,
  input  logic [9:0] y_shooter,
  input  logic [2:0] player_score,
  input  logic       is_scored,
  input  logic       multi_input,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  state_e       state_q, state_d;
  logic [2:0]   idx_q,   idx_d;
  logic [CW-1:0] gap_q,  gap_d;
  snapshot_t    snap_q,  snap_d;
  logic         wr_q,    wr_d;
  logic [7:0]   data_q,  data_d;
  logic [7:0]   frame_byte;

  uart_frame_builder u_frame_builder (
    .snap  (snap_q),
    .idx   (idx_q),
    .frame (frame_byte)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    snap_d  = snap_q;
    wr_d    = 1'b0;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (send_tick) begin
          snap_d = '{local_shooter: local_shooter, game_starts: game_starts,
                     keeper_pos: keeper_pos, x_shooter: x_shooter,
                     y_shooter: y_shooter, player_score: player_score,
                     is_scored: is_scored, multi_input: multi_input};
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // A full FIFO simply parks here; the frame index does not move.
        if (!tx_full) begin
          wr_d    = 1'b1;
          data_d  = frame_byte;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          idx_d   = idx_q + 3'd1;   // wraps to 0 after the last frame
          state_d = (idx_q == 3'd7) ? ST_IDLE : ST_SEND;
        end else begin
          gap_d = gap_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      gap_q   <= '0;
      // NOTE: the snapshot register is reset too, so nothing stale can leak into w_data after reset.
      snap_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      snap_q  <= snap_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  assign wr_uart = wr_q;
  assign w_data  = data_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_encoder.sv
module tb_uart_encoder;

  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_tick = 1'b0;
  logic       tx_full = 1'b0;
  logic       local_shooter = 1'b0;
  logic       game_starts = 1'b0;
  logic [9:0] keeper_pos = '0;
  logic [9:0] x_shooter = '0;
  logic [9:0] y_shooter = '0;
  logic [2:0] player_score = '0;
  logic       is_scored = 1'b0;
  logic       multi_input = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference copy of the snapshot the current burst must carry.
  logic       m_ls, m_gs, m_sc, m_mi;
  logic [9:0] m_kp, m_xs, m_ys;
  logic [2:0] m_ps;

  uart_encoder #(.GAP_CYCLES(GAP)) dut (
    .clk           (clk),
    .rst           (rst),
    .send_tick     (send_tick),
    .tx_full       (tx_full),
    .local_shooter (local_shooter),
    .game_starts   (game_starts),
    .keeper_pos    (keeper_pos),
    .x_shooter     (x_shooter),
    .y_shooter     (y_shooter),
    .player_score  (player_score),
    .is_scored     (is_scored),
    .multi_input   (multi_input),
    .wr_uart       (wr_uart),
    .w_data        (w_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive_random_data();
    local_shooter = 1'($urandom);
    game_starts   = 1'($urandom);
    keeper_pos    = 10'($urandom);
    x_shooter     = 10'($urandom);
    y_shooter     = 10'($urandom);
    player_score  = 3'($urandom);
    is_scored     = 1'($urandom);
    multi_input   = 1'($urandom);
  endtask

  // Expected byte k = payload * 8 + k, payload taken from the field rules.
  function automatic logic [7:0] exp_byte(input int k);
    int field, payload;
    case (k)
      0: payload = (m_gs && m_ls) ? 25 : (m_gs ? 9 : 1);
      7: payload = int'(m_mi) * 16 + int'(m_sc) * 8 + int'(m_ps);
      default: begin
        field   = (k <= 2) ? int'(m_kp) : ((k <= 4) ? int'(m_xs) : int'(m_ys));
        payload = (k % 2 == 1) ? field % 32 : field / 32;
      end
    endcase
    return 8'(payload * 8 + k);
  endfunction

  // One burst: send_tick at edge 0, then edge-by-edge comparison against
  // the timing model. tx_full "in cycle c" is sampled at edge c+1.
  task automatic run_burst(input logic ls, gs, input logic [9:0] kp, xs, ys,
                           input logic [2:0] ps, input logic sc, mi,
                           input int bp_lo, bp_hi, input bit rand_bp,
                           input int abort_at, input bit retrig);
    int  k = 0, next_ok = 1, last_wr = -100;
    bit  finished = 0, exp_wr, exp_busy;
    m_ls = ls; m_gs = gs; m_kp = kp; m_xs = xs; m_ys = ys;
    m_ps = ps; m_sc = sc; m_mi = mi;
    local_shooter = ls; game_starts = gs; keeper_pos = kp; x_shooter = xs;
    y_shooter = ys; player_score = ps; is_scored = sc; multi_input = mi;
    tx_full = 1'b0;
    send_tick = 1'b1;
    @(posedge clk); #1;
    send_tick = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_no_wr", 32'(wr_uart), 32'd0);
    for (int e = 1; e <= 400; e++) begin
      tx_full = rand_bp ? ($urandom_range(0, 3) == 0) : (e >= bp_lo && e <= bp_hi);
      drive_random_data();   // the burst must ignore these
      send_tick = retrig && (e == 4 || (k == 8 && e == last_wr + GAP));
      @(posedge clk); #1;
      exp_wr = (k < 8) && (e >= next_ok) && !tx_full;
      check($sformatf("wr_e%0d", e), 32'(wr_uart), 32'(exp_wr));
      if (exp_wr) begin
        check($sformatf("byte%0d", k), 32'(w_data), 32'(exp_byte(k)));
        k++;
        next_ok = e + 1 + GAP;
        last_wr = e;
      end
      exp_busy = !(k == 8 && e >= last_wr + GAP);
      check($sformatf("busy_e%0d", e), 32'(busy), 32'(exp_busy));
      send_tick = 1'b0;
      if (e == abort_at) begin
        rst = 1'b1; #1;
        check("abort_wr", 32'(wr_uart), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(w_data), 32'd0);
        #2 rst = 1'b0;
        return;
      end
      if (k == 8 && e >= last_wr + GAP + 4) begin
        finished = 1;
        break;
      end
    end
    check("burst_completed", 32'(finished), 32'd1);
    tx_full = 1'b0;
  endtask

  initial begin
    // Reset with random inputs on every pin.
    drive_random_data();
    send_tick = 1'b1;
    tx_full = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr", 32'(wr_uart), 32'd0);
    check("rst_data", 32'(w_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    send_tick = 1'b0;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_random_data();
      tx_full = 1'($urandom);
      @(posedge clk); #1;
      check("idle_wr", 32'(wr_uart), 32'd0);
    end
    check("idle_busy", 32'(busy), 32'd0);

    // Directed burst: bytes C8 29 AA 03 A4 FD 76 AF in cycles 1,3,..,15.
    run_burst(1, 1, 10'h2A5, 10'd640, 10'd479, 3'd5, 0, 1, -1, -1, 0, -1, 0);
    check("dir_b0", 32'(exp_byte(0)), 32'hC8);
    check("dir_b7", 32'(exp_byte(7)), 32'hAF);
    // Backpressure in cycles 4..9: frame 2 lands in cycle 11.
    run_burst(1, 1, 10'h2A5, 10'd640, 10'd479, 3'd5, 0, 1, 5, 10, 0, -1, 0);
    // Mid-burst and end-of-burst send_tick must be ignored.
    run_burst(1, 1, 10'h2A5, 10'd640, 10'd479, 3'd5, 0, 1, -1, -1, 0, -1, 1);
    // Sync corners.
    run_burst(1, 0, 10'($urandom), 10'($urandom), 10'($urandom), 3'($urandom), 1, 0, -1, -1, 0, -1, 0);
    run_burst(0, 1, 10'($urandom), 10'($urandom), 10'($urandom), 3'($urandom), 0, 1, -1, -1, 0, -1, 0);
    // Reset in cycle 6, then a fresh burst from frame 0.
    run_burst(1, 1, 10'h2A5, 10'd640, 10'd479, 3'd5, 0, 1, -1, -1, 0, 6, 0);
    repeat (2) @(posedge clk);
    #1 check("post_abort_idle", 32'(busy), 32'd0);
    run_burst(0, 0, 10'h155, 10'h3FF, 10'h000, 3'd7, 1, 1, -1, -1, 0, -1, 0);

    // Randomised bursts with random backpressure.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_burst(1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom),
                10'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                -1, -1, 1, -1, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
